// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encoding and defaults for the IF/MEM unified memory port arbiter.
// The timeout logic is built only when ARB_TIMEOUT_EN is defined.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_IF_ACC = 2'd1,
    ARB_DM_ACC = 2'd2
  } arb_state_e;

  localparam int unsigned ARB_TIMEOUT_DEFAULT = 255;

  // The wait counter is never narrower than 8 bits.
  function automatic int unsigned arb_cnt_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// Wait counter that aborts a memory access after TIMEOUT_CYCLES cycles without an ack.
// The module is only compiled when ARB_TIMEOUT_EN is defined.
`ifdef ARB_TIMEOUT_EN
module arb_wait_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic active_i,
  input  logic ack_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = arb_cnt_width(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The cycle in which the counter holds TIMEOUT_CYCLES-1 is the last allowed wait cycle.
  assign expired_o = active_i & ~ack_i & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (active_i && !ack_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory bus between instruction fetch and load/store.
// Optional access timeout is enabled with the ARB_TIMEOUT_EN macro.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                If_req,
  input  logic [ADDR_W-1:0]   If_addr,
  output logic [DATA_W-1:0]   If_rdata,
  output logic                If_ready,
  input  logic                Dm_req,
  input  logic                Dm_we,
  input  logic [ADDR_W-1:0]   Dm_addr,
  input  logic [DATA_W-1:0]   Dm_wdata,
  input  logic [DATA_W/8-1:0] Dm_be,
  output logic [DATA_W-1:0]   Dm_rdata,
  output logic                Dm_ready,
  output logic                Mem_req,
  output logic                Mem_we,
  output logic [ADDR_W-1:0]   Mem_addr,
  output logic [DATA_W-1:0]   Mem_wdata,
  output logic [DATA_W/8-1:0] Mem_be,
  input  logic                Mem_ack,
  input  logic [DATA_W-1:0]   Mem_rdata,
  output logic                Mem_timeout,
  output logic                Stall_mem_port
);

  arb_state_e          state_q, state_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] be_q, be_d;
  logic                grant_if, grant_dm, done, expired;

`ifdef ARB_TIMEOUT_EN
  arb_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_i     (Clk),
    .rst_ni    (Rst_n),
    .clear_i   (grant_if | grant_dm),
    .active_i  (state_q != ARB_IDLE),
    .ack_i     (Mem_ack),
    .expired_o (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // An ack seen in IDLE is not qualified by an outstanding request and is dropped.
  assign done        = (state_q != ARB_IDLE) & (Mem_ack | expired);
  assign If_ready    = (state_q == ARB_IF_ACC) & done;
  assign Dm_ready    = (state_q == ARB_DM_ACC) & done;
  assign If_rdata    = expired ? '0 : Mem_rdata;
  assign Dm_rdata    = expired ? '0 : Mem_rdata;
  assign Mem_timeout = expired;
  assign Stall_mem_port = (If_req & ~If_ready) | (Dm_req & ~Dm_ready);

  assign Mem_req   = req_q;
  assign Mem_we    = we_q;
  assign Mem_addr  = addr_q;
  assign Mem_wdata = wdata_q;
  assign Mem_be    = be_q;

  // On completion only the other requester may be granted, which enforces alternation.
  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (Dm_req)      grant_dm = 1'b1;
        else if (If_req) grant_if = 1'b1;
      end
      ARB_IF_ACC: begin
        if (done) begin
          if (Dm_req) grant_dm = 1'b1;
          else        state_d  = ARB_IDLE;
        end
      end
      ARB_DM_ACC: begin
        if (done) begin
          if (If_req) grant_if = 1'b1;
          else        state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (grant_dm) state_d = ARB_DM_ACC;
    if (grant_if) state_d = ARB_IF_ACC;
  end

  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    if (grant_dm) begin
      req_d   = 1'b1;
      we_d    = Dm_we;
      addr_d  = Dm_addr;
      wdata_d = Dm_wdata;
      be_d    = Dm_be;
    end else if (grant_if) begin
      req_d  = 1'b1;
      we_d   = 1'b0;
      addr_d = If_addr;
      be_d   = '1;
    end else if (done) begin
      req_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= ARB_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; covers the ARB_TIMEOUT_EN build when defined.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        If_req;
  logic [31:0] If_addr;
  logic [31:0] If_rdata;
  logic        If_ready;
  logic        Dm_req;
  logic        Dm_we;
  logic [31:0] Dm_addr;
  logic [31:0] Dm_wdata;
  logic [3:0]  Dm_be;
  logic [31:0] Dm_rdata;
  logic        Dm_ready;
  logic        Mem_req;
  logic        Mem_we;
  logic [31:0] Mem_addr;
  logic [31:0] Mem_wdata;
  logic [3:0]  Mem_be;
  logic        Mem_ack;
  logic [31:0] Mem_rdata;
  logic        Mem_timeout;
  logic        Stall_mem_port;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 Clk = ~Clk;

  mem_port_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .Clk            (Clk),
    .Rst_n          (Rst_n),
    .If_req         (If_req),
    .If_addr        (If_addr),
    .If_rdata       (If_rdata),
    .If_ready       (If_ready),
    .Dm_req         (Dm_req),
    .Dm_we          (Dm_we),
    .Dm_addr        (Dm_addr),
    .Dm_wdata       (Dm_wdata),
    .Dm_be          (Dm_be),
    .Dm_rdata       (Dm_rdata),
    .Dm_ready       (Dm_ready),
    .Mem_req        (Mem_req),
    .Mem_we         (Mem_we),
    .Mem_addr       (Mem_addr),
    .Mem_wdata      (Mem_wdata),
    .Mem_be         (Mem_be),
    .Mem_ack        (Mem_ack),
    .Mem_rdata      (Mem_rdata),
    .Mem_timeout    (Mem_timeout),
    .Stall_mem_port (Stall_mem_port)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Present an ack with read data and let the combinational outputs settle.
  task automatic ack(input logic [31:0] rdata);
    Mem_ack   = 1'b1;
    Mem_rdata = rdata;
    #1;
  endtask

  initial begin
    Rst_n = 1'b0; If_req = 1'b1; If_addr = 32'h100;
    Dm_req = 1'b0; Dm_we = 1'b0; Dm_addr = '0; Dm_wdata = '0; Dm_be = '0;
    Mem_ack = 1'b0; Mem_rdata = '0;

    // Reset held three cycles with a pending fetch.
    step(); step(); step();
    chk("rst_mem_req", Mem_req, 1'b0);
    chk("rst_mem_addr", Mem_addr, 32'h0);
    chk("rst_mem_be", Mem_be, 4'h0);
    chk("rst_timeout", Mem_timeout, 1'b0);
    chk("rst_stall", Stall_mem_port, 1'b1);
    Rst_n = 1'b1;

    // Lone fetch, ack two cycles after Mem_req rises.
    step();
    chk("if_grant_req", Mem_req, 1'b1);
    chk("if_grant_addr", Mem_addr, 32'h100);
    chk("if_grant_we", Mem_we, 1'b0);
    chk("if_grant_be", Mem_be, 4'hF);
    chk("if_wait_ready", If_ready, 1'b0);
    step();
    chk("if_wait2_req", Mem_req, 1'b1);
    chk("if_wait2_stall", Stall_mem_port, 1'b1);
    step();
    ack(32'h00A00093);
    chk("if_ready", If_ready, 1'b1);
    chk("if_rdata", If_rdata, 32'h00A00093);
    chk("if_ack_stall", Stall_mem_port, 1'b0);
    chk("if_ack_dm_ready", Dm_ready, 1'b0);
    step();
    Mem_ack = 1'b0; If_req = 1'b0;
    #1;
    chk("if_done_req", Mem_req, 1'b0);
    chk("if_done_ready", If_ready, 1'b0);

    // Simultaneous requests: data first, then fetch with no idle gap.
    If_req = 1'b1; If_addr = 32'h104;
    Dm_req = 1'b1; Dm_we = 1'b0; Dm_addr = 32'h2000; Dm_be = 4'hF;
    step();
    chk("sim_dm_first_addr", Mem_addr, 32'h2000);
    chk("sim_dm_first_we", Mem_we, 1'b0);
    ack(32'h11112222);
    chk("sim_dm_ready", Dm_ready, 1'b1);
    chk("sim_dm_rdata", Dm_rdata, 32'h11112222);
    chk("sim_if_not_ready", If_ready, 1'b0);
    chk("sim_stall_if_pending", Stall_mem_port, 1'b1);
    step();
    Mem_ack = 1'b0; Dm_req = 1'b0;
    #1;
    chk("sim_if_next_req", Mem_req, 1'b1);
    chk("sim_if_next_addr", Mem_addr, 32'h104);
    chk("sim_if_next_be", Mem_be, 4'hF);
    ack(32'h33334444);
    chk("sim_if_ready", If_ready, 1'b1);
    chk("sim_if_rdata", If_rdata, 32'h33334444);
    step();
    Mem_ack = 1'b0; If_req = 1'b0;
    #1;
    chk("sim_idle_req", Mem_req, 1'b0);

    // Fairness: three back-to-back stores interleaved with fetches.
    If_req = 1'b1; If_addr = 32'h108;
    Dm_req = 1'b1; Dm_we = 1'b1; Dm_addr = 32'h3000; Dm_wdata = 32'hA0; Dm_be = 4'hF;
    step();
    chk("fair_g1_addr", Mem_addr, 32'h3000);
    chk("fair_g1_we", Mem_we, 1'b1);
    ack(32'h0);
    chk("fair_g1_dm_ready", Dm_ready, 1'b1);
    step();
    Mem_ack = 1'b0; Dm_addr = 32'h3004; Dm_wdata = 32'hA1;
    #1;
    chk("fair_g2_addr", Mem_addr, 32'h108);
    chk("fair_g2_we", Mem_we, 1'b0);
    ack(32'h55);
    chk("fair_g2_if_ready", If_ready, 1'b1);
    step();
    Mem_ack = 1'b0; If_addr = 32'h10C;
    #1;
    chk("fair_g3_addr", Mem_addr, 32'h3004);
    chk("fair_g3_wdata", Mem_wdata, 32'hA1);
    ack(32'h0);
    chk("fair_g3_dm_ready", Dm_ready, 1'b1);
    step();
    Mem_ack = 1'b0; Dm_addr = 32'h3008; Dm_wdata = 32'hA2;
    #1;
    chk("fair_g4_addr", Mem_addr, 32'h10C);
    ack(32'h66);
    chk("fair_g4_if_ready", If_ready, 1'b1);
    step();
    Mem_ack = 1'b0; If_addr = 32'h110;
    #1;
    chk("fair_g5_addr", Mem_addr, 32'h3008);
    chk("fair_g5_wdata", Mem_wdata, 32'hA2);
    ack(32'h0);
    step();
    Mem_ack = 1'b0; Dm_req = 1'b0;
    #1;
    chk("fair_g6_addr", Mem_addr, 32'h110);
    ack(32'h77);
    chk("fair_g6_if_rdata", If_rdata, 32'h77);
    step();
    Mem_ack = 1'b0; If_req = 1'b0;
    #1;
    chk("fair_idle_req", Mem_req, 1'b0);

    // Partial store with byte enables.
    Dm_req = 1'b1; Dm_we = 1'b1; Dm_be = 4'b0011; Dm_wdata = 32'hDEADBEEF; Dm_addr = 32'h4000;
    step();
    chk("st_we", Mem_we, 1'b1);
    chk("st_be", Mem_be, 4'b0011);
    chk("st_wdata", Mem_wdata, 32'hDEADBEEF);
    chk("st_addr", Mem_addr, 32'h4000);
    ack(32'h0);
    chk("st_ready", Dm_ready, 1'b1);
    step();
    Mem_ack = 1'b0; Dm_req = 1'b0;
    #1;
    chk("st_idle_req", Mem_req, 1'b0);

    // Ack while idle is ignored.
    ack(32'h99);
    chk("idle_ack_dm_ready", Dm_ready, 1'b0);
    chk("idle_ack_if_ready", If_ready, 1'b0);
    Mem_ack = 1'b0;

    // Reset mid-access, then a late ack.
    Dm_req = 1'b1; Dm_addr = 32'h4004;
    step();
    chk("st2_req", Mem_req, 1'b1);
    Rst_n = 1'b0;
    step();
    chk("midrst_req", Mem_req, 1'b0);
    chk("midrst_we", Mem_we, 1'b0);
    Rst_n = 1'b1; Dm_req = 1'b0;
    ack(32'hBAD);
    chk("late_ack_dm_ready", Dm_ready, 1'b0);
    step();
    Mem_ack = 1'b0;
    #1;
    chk("late_ack_req", Mem_req, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // No ack: the 4th wait cycle aborts the fetch.
    If_req = 1'b1; If_addr = 32'h200; Mem_rdata = 32'hFFFF0000;
    step();
    chk("to_w1_ready", If_ready, 1'b0);
    chk("to_w1_timeout", Mem_timeout, 1'b0);
    step();
    step();
    chk("to_w3_ready", If_ready, 1'b0);
    step();
    chk("to_w4_ready", If_ready, 1'b1);
    chk("to_w4_rdata", If_rdata, 32'h0);
    chk("to_w4_timeout", Mem_timeout, 1'b1);
    step();
    If_req = 1'b0;
    #1;
    chk("to_after_req", Mem_req, 1'b0);
    chk("to_after_timeout", Mem_timeout, 1'b0);
`else
    // No ack for many cycles: the fetch keeps waiting.
    If_req = 1'b1; If_addr = 32'h200;
    for (int i = 0; i < 8; i++) step();
    chk("nto_req_held", Mem_req, 1'b1);
    chk("nto_timeout", Mem_timeout, 1'b0);
    chk("nto_ready", If_ready, 1'b0);
    ack(32'h1234);
    chk("nto_ready_on_ack", If_ready, 1'b1);
    step();
    Mem_ack = 1'b0; If_req = 1'b0;
    #1;
    chk("nto_idle_req", Mem_req, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
